spram_arbiter: RTL and testbench
================================

SPRAM_ARBITER -- requirements
Module: spram_arbiter

Interface
REQ-001 SHALL have parameter MAX_BURST, default 4: maximum consecutive grants to one requester while the other requester waits (legal range 1..15).
REQ-002 SHALL have parameter ADDR_W, default 14: word-address width of the shared SPRAM.
REQ-003 SHALL have port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port rstn  input  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have ports a_valid/b_valid  input  1  request from requester A (CPU) / B (UART loader).
REQ-006 SHALL have ports a_ready/b_ready  output  1  request accepted this cycle.
REQ-007 SHALL have ports a_write/b_write  input  1; a_wmask/b_wmask  input  4; a_wdata/b_wdata  input  32; a_addr/b_addr  input  ADDR_W.
REQ-008 SHALL have ports a_rdata/b_rdata  output  32; a_rvalid/b_rvalid  output  1  read data valid.
REQ-009 SHALL have ports ram_valid, ram_write  output  1; ram_wmask  output  4; ram_wdata  output  32; ram_addr  output  ADDR_W; ram_rdata  input  32  (SPRAM read latency 1 cycle).

Function
REQ-010 SHALL accept at most one request per cycle; x_ready is combinational from x_valid and registered state; handshake completes when x_valid & x_ready.
REQ-011 SHALL drive ram_* combinationally from the granted requester; ram_valid = a_valid | b_valid; ram_write = granted x_write.
REQ-012 SHALL grant the only requester when exactly one x_valid is high, regardless of state.
REQ-013 SHALL, on simultaneous a_valid & b_valid, grant the requester held in register owner unless burst counter == MAX_BURST, in which case grant the other.
REQ-014 SHALL update owner to the granted requester on every accepted request.
REQ-015 SHALL increment burst counter on an accepted request to the same owner while the other x_valid is high; reset it to 1 on an owner change; reset it to 0 when the other requester is idle; saturate at MAX_BURST.
REQ-016 SHALL assert x_rvalid for exactly one cycle, the cycle after an accepted read by x, with x_rdata = ram_rdata in that cycle.
REQ-017 SHALL hold x_rvalid low for writes; writes produce no response.
REQ-018 SHALL drive a_rdata and b_rdata from ram_rdata at all times; only x_rvalid qualifies them.
REQ-019 SHALL sustain one accepted request per cycle back-to-back with no bubble, including across owner changes.
REQ-020 SHALL, with MAX_BURST = 1 and both requesting continuously, alternate A,B,A,B...
REQ-021 SHALL allow a requester to drop x_valid while waiting without penalty; counter then resets per REQ-015.

Reset
REQ-022 SHALL, while rstn low, force owner = A, burst counter = 0, a_rvalid = b_rvalid = 0.
REQ-023 SHALL discard a read accepted in the cycle of reset assertion; no rvalid follows release.
REQ-024 SHALL keep a_ready, b_ready, ram_valid low during reset regardless of x_valid.

Structure
REQ-025 SHALL place the requester encoding constants (REQ_A = 0, REQ_B = 1) and default MAX_BURST in the shared memory-system package/include used by the board wrappers.
REQ-026 SHALL be a single module with no sub-modules; SPRAM macros stay instantiated outside, in the existing SPRAM memory wrapper.

Verification
REQ-027 SHALL cover: A-only read at addr 0x0010, ram_rdata 0x1234_5678 -> a_ready same cycle, a_rvalid and a_rdata 0x1234_5678 next cycle, b_rvalid 0.
REQ-028 SHALL cover: both valid continuously, MAX_BURST = 4, reset owner A -> grants A,A,A,A,B,B,B,B,A...
REQ-029 SHALL cover: B write, wmask 4'b0011, wdata 0xDEAD_BEEF, addr 0x3FFF, simultaneous A idle -> ram_write 1, ram_wmask 0011, ram_addr 0x3FFF, no rvalid.
REQ-030 SHALL cover: A read accepted, rstn asserted asynchronously the same cycle -> a_rvalid 0 during and after reset, owner A, counter 0.
REQ-031 SHALL cover: MAX_BURST = 1, both valid 6 cycles -> A,B,A,B,A,B; B drops valid after 2 grants -> A granted every cycle, counter 0.

Source files
------------

// File: rtl/spram_arbiter_pkg.sv
// Shared memory-system constants for the SPRAM arbiter.
// Requester encoding and default sizing used by the board wrappers.
package spram_arbiter_pkg;

    typedef enum logic {
        REQ_A = 1'b0,
        REQ_B = 1'b1
    } req_e;

    localparam int MAX_BURST_DFLT = 4;
    localparam int ADDR_W_DFLT    = 14;
    localparam int CNT_W          = 4;

endpackage

// File: rtl/spram_arbiter.sv
// Two-requester arbiter in front of a single-port SPRAM.
// Sticky owner with a burst limit; one-cycle read response per requester.
module spram_arbiter
    import spram_arbiter_pkg::*;
#(
    parameter int MAX_BURST = MAX_BURST_DFLT,
    parameter int ADDR_W    = ADDR_W_DFLT
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              a_valid,
    output logic              a_ready,
    input  logic              a_write,
    input  logic [3:0]        a_wmask,
    input  logic [31:0]       a_wdata,
    input  logic [ADDR_W-1:0] a_addr,
    output logic [31:0]       a_rdata,
    output logic              a_rvalid,
    input  logic              b_valid,
    output logic              b_ready,
    input  logic              b_write,
    input  logic [3:0]        b_wmask,
    input  logic [31:0]       b_wdata,
    input  logic [ADDR_W-1:0] b_addr,
    output logic [31:0]       b_rdata,
    output logic              b_rvalid,
    output logic              ram_valid,
    output logic              ram_write,
    output logic [3:0]        ram_wmask,
    output logic [31:0]       ram_wdata,
    output logic [ADDR_W-1:0] ram_addr,
    input  logic [31:0]       ram_rdata
);

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BURST);

    req_e             owner_q, owner_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             a_rpend_q, a_rpend_d;
    logic             b_rpend_q, b_rpend_d;
    logic             gnt_a, gnt_b;
    logic             other_valid;
    req_e             gnt_req;

    // Grant: lone requester wins; on contention the owner keeps it until the burst limit.
    always_comb begin
        gnt_a = 1'b0;
        gnt_b = 1'b0;
        if (rstn) begin
            if (a_valid && b_valid) begin
                if (cnt_q == MAX_CNT) begin
                    gnt_b = (owner_q == REQ_A);
                end else begin
                    gnt_b = (owner_q == REQ_B);
                end
                gnt_a = ~gnt_b;
            end else begin
                gnt_a = a_valid;
                gnt_b = b_valid;
            end
        end
    end

    assign a_ready   = gnt_a;
    assign b_ready   = gnt_b;
    assign ram_valid = gnt_a | gnt_b;
    assign ram_write = gnt_b ? b_write : a_write;
    assign ram_wmask = gnt_b ? b_wmask : a_wmask;
    assign ram_wdata = gnt_b ? b_wdata : a_wdata;
    assign ram_addr  = gnt_b ? b_addr  : a_addr;
    assign a_rdata   = ram_rdata;
    assign b_rdata   = ram_rdata;
    assign a_rvalid  = a_rpend_q;
    assign b_rvalid  = b_rpend_q;

    // Owner/burst bookkeeping and read-response tracking for the next cycle.
    always_comb begin
        owner_d     = owner_q;
        cnt_d       = cnt_q;
        gnt_req     = gnt_b ? REQ_B : REQ_A;
        other_valid = gnt_b ? a_valid : b_valid;
        a_rpend_d   = gnt_a & ~a_write;
        b_rpend_d   = gnt_b & ~b_write;
        if (gnt_a || gnt_b) begin
            owner_d = gnt_req;
            if (!other_valid) begin
                cnt_d = '0;
            end else if (gnt_req != owner_q) begin
                cnt_d = CNT_W'(1);
            end else if (cnt_q != MAX_CNT) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // State registers; reset drops any read accepted as reset hits.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_q   <= REQ_A;
            cnt_q     <= '0;
            a_rpend_q <= 1'b0;
            b_rpend_q <= 1'b0;
        end else begin
            owner_q   <= owner_d;
            cnt_q     <= cnt_d;
            a_rpend_q <= a_rpend_d;
            b_rpend_q <= b_rpend_d;
        end
    end

endmodule

// File: tb/tb_spram_arbiter.sv
// Directed bench for spram_arbiter.
// Runs MAX_BURST=4 and MAX_BURST=1 instances side by side on shared stimulus.
module tb_spram_arbiter;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        a_valid = 1'b0, b_valid = 1'b0;
    logic        a_write = 1'b0, b_write = 1'b0;
    logic [3:0]  a_wmask = 4'h0, b_wmask = 4'h0;
    logic [31:0] a_wdata = '0, b_wdata = '0;
    logic [13:0] a_addr = '0, b_addr = '0;
    logic [31:0] ram_rdata = '0;

    logic        a_ready4, b_ready4, a_rvalid4, b_rvalid4;
    logic [31:0] a_rdata4, b_rdata4, ram_wdata4;
    logic        ram_valid4, ram_write4;
    logic [3:0]  ram_wmask4;
    logic [13:0] ram_addr4;

    logic        a_ready1, b_ready1, a_rvalid1, b_rvalid1;
    logic [31:0] a_rdata1, b_rdata1, ram_wdata1;
    logic        ram_valid1, ram_write1;
    logic [3:0]  ram_wmask1;
    logic [13:0] ram_addr1;

    int passed = 0;
    int total  = 0;

    bit exp4 [9] = '{1, 1, 1, 1, 0, 0, 0, 0, 1};
    bit exp1 [9] = '{1, 0, 1, 0, 1, 0, 1, 0, 1};

    always #5 clk = ~clk;

    spram_arbiter #(.MAX_BURST(4), .ADDR_W(14)) dut4 (
        .clk(clk), .rstn(rstn),
        .a_valid(a_valid), .a_ready(a_ready4), .a_write(a_write),
        .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
        .a_rdata(a_rdata4), .a_rvalid(a_rvalid4),
        .b_valid(b_valid), .b_ready(b_ready4), .b_write(b_write),
        .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
        .b_rdata(b_rdata4), .b_rvalid(b_rvalid4),
        .ram_valid(ram_valid4), .ram_write(ram_write4),
        .ram_wmask(ram_wmask4), .ram_wdata(ram_wdata4),
        .ram_addr(ram_addr4), .ram_rdata(ram_rdata)
    );

    spram_arbiter #(.MAX_BURST(1), .ADDR_W(14)) dut1 (
        .clk(clk), .rstn(rstn),
        .a_valid(a_valid), .a_ready(a_ready1), .a_write(a_write),
        .a_wmask(a_wmask), .a_wdata(a_wdata), .a_addr(a_addr),
        .a_rdata(a_rdata1), .a_rvalid(a_rvalid1),
        .b_valid(b_valid), .b_ready(b_ready1), .b_write(b_write),
        .b_wmask(b_wmask), .b_wdata(b_wdata), .b_addr(b_addr),
        .b_rdata(b_rdata1), .b_rvalid(b_rvalid1),
        .ram_valid(ram_valid1), .ram_write(ram_write1),
        .ram_wmask(ram_wmask1), .ram_wdata(ram_wdata1),
        .ram_addr(ram_addr1), .ram_rdata(ram_rdata)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        a_valid = 1'b0;
        b_valid = 1'b0;
        a_write = 1'b0;
        b_write = 1'b0;
        rstn    = 1'b0;
        next_cycle();
        next_cycle();
        rstn = 1'b1;
    endtask

    initial begin
        // Reset: valids high must not leak through
        a_valid = 1'b1;
        b_valid = 1'b1;
        @(negedge clk);
        chk("rst_a_ready", a_ready4, 0);
        chk("rst_b_ready", b_ready4, 0);
        chk("rst_ram_valid", ram_valid4, 0);
        chk("rst_a_rvalid", a_rvalid4, 0);
        chk("rst_b_rvalid", b_rvalid4, 0);
        next_cycle();
        do_reset();

        // A-only read
        a_valid   = 1'b1;
        a_addr    = 14'h0010;
        ram_rdata = 32'h1234_5678;
        @(negedge clk);
        chk("rd_a_ready", a_ready4, 1);
        chk("rd_b_ready", b_ready4, 0);
        chk("rd_ram_valid", ram_valid4, 1);
        chk("rd_ram_write", ram_write4, 0);
        chk("rd_ram_addr", ram_addr4, 32'h10);
        next_cycle();
        a_valid = 1'b0;
        @(negedge clk);
        chk("rd_a_rvalid", a_rvalid4, 1);
        chk("rd_a_rdata", a_rdata4, 32'h1234_5678);
        chk("rd_b_rvalid", b_rvalid4, 0);
        next_cycle();
        @(negedge clk);
        chk("rd_a_rvalid_once", a_rvalid4, 0);
        next_cycle();

        // B write, A idle
        b_valid = 1'b1;
        b_write = 1'b1;
        b_wmask = 4'b0011;
        b_wdata = 32'hDEAD_BEEF;
        b_addr  = 14'h3FFF;
        @(negedge clk);
        chk("wr_b_ready", b_ready4, 1);
        chk("wr_a_ready", a_ready4, 0);
        chk("wr_ram_write", ram_write4, 1);
        chk("wr_ram_wmask", ram_wmask4, 4'b0011);
        chk("wr_ram_wdata", ram_wdata4, 32'hDEAD_BEEF);
        chk("wr_ram_addr", ram_addr4, 32'h3FFF);
        next_cycle();
        b_valid = 1'b0;
        b_write = 1'b0;
        @(negedge clk);
        chk("wr_b_rvalid", b_rvalid4, 0);
        chk("wr_a_rvalid", a_rvalid4, 0);
        next_cycle();

        // Continuous contention from reset
        do_reset();
        a_addr  = 14'h0001;
        b_addr  = 14'h0002;
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            chk($sformatf("b4_a_ready_%0d", i), a_ready4, exp4[i]);
            chk($sformatf("b4_b_ready_%0d", i), b_ready4, !exp4[i]);
            chk($sformatf("b4_addr_%0d", i), ram_addr4, exp4[i] ? 1 : 2);
            chk($sformatf("b1_a_ready_%0d", i), a_ready1, exp1[i]);
            chk($sformatf("b1_b_ready_%0d", i), b_ready1, !exp1[i]);
            if (i > 0) begin
                chk($sformatf("b4_a_rvalid_%0d", i), a_rvalid4, exp4[i-1]);
                chk($sformatf("b4_b_rvalid_%0d", i), b_rvalid4, !exp4[i-1]);
            end
            next_cycle();
        end

        // MAX_BURST=1: B drops after two grants, then returns
        do_reset();
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("alt_a_ready_%0d", i), a_ready1, exp1[i]);
            next_cycle();
        end
        b_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("solo_a_ready_%0d", i), a_ready1, 1);
            chk($sformatf("solo_b_ready_%0d", i), b_ready1, 0);
            next_cycle();
        end
        b_valid = 1'b1;
        @(negedge clk);
        chk("back_a_first", a_ready1, 1);
        next_cycle();
        @(negedge clk);
        chk("back_b_second", b_ready1, 1);
        next_cycle();

        // Reset asserted in the cycle of an accepted read
        do_reset();
        b_valid = 1'b0;
        a_valid = 1'b1;
        @(negedge clk);
        chk("ar_a_ready_pre", a_ready4, 1);
        #2;
        rstn = 1'b0;
        #1;
        chk("ar_a_ready_rst", a_ready4, 0);
        chk("ar_ram_valid_rst", ram_valid4, 0);
        next_cycle();
        chk("ar_a_rvalid_rst", a_rvalid4, 0);
        next_cycle();
        a_valid = 1'b0;
        rstn    = 1'b1;
        @(negedge clk);
        chk("ar_a_rvalid_post", a_rvalid4, 0);
        next_cycle();
        a_valid = 1'b1;
        b_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("ar_b4_a_ready_%0d", i), a_ready4, exp4[i]);
            chk($sformatf("ar_b1_a_ready_%0d", i), a_ready1, exp1[i]);
            next_cycle();
        end
        a_valid = 1'b0;
        b_valid = 1'b0;
        next_cycle();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
